// File: rtl/scaler_pkg.sv
// scaler_pkg: shared constants, types and helpers for the horizontal scaler.
// No ports; imported by scaler_horizontal and scaler_h_interp.
package scaler_pkg;

    localparam int PIXEL_STEP_DEF = 4096;
    localparam int FRAC_W         = $clog2(PIXEL_STEP_DEF);
    localparam int INT_W          = 16;
    localparam int ACC_W          = INT_W + FRAC_W;
    localparam int STEP_W         = 16;
    localparam int PIPE_LAT       = 3;

    // Line tracker: WAIT holds off all output until the first
    // horizontal blank after reset gives a clean line start.
    typedef enum logic [1:0] {
        LS_WAIT,
        LS_BLANK,
        LS_ACTIVE
    } line_state_e;

    // Steps below unity would mean upscaling, which the single
    // output-per-input emit rule cannot produce; force them to 1.0.
    function automatic logic [STEP_W-1:0] clamp_step(
        input logic [STEP_W-1:0] step,
        input logic [STEP_W-1:0] unity
    );
        return (step < unity) ? unity : step;
    endfunction

endpackage

// File: rtl/scaler_h_interp.sv
// scaler_h_interp: two-stage registered two-tap blend with rounding.
// Ports: clk, rst (sync, active-low), in_valid/p0/p1/w in,
//        out_valid/out_data out (out_data holds while out_valid=0).
module scaler_h_interp
    import scaler_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int WEIGHT_W   = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] p0,
    input  logic [DATA_WIDTH-1:0] p1,
    input  logic [WEIGHT_W-1:0]   w,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    localparam int PW = DATA_WIDTH + WEIGHT_W + 1;
    localparam logic [WEIGHT_W:0] W_ONE = {1'b1, {WEIGHT_W{1'b0}}};
    localparam logic [PW-1:0] RND = PW'(W_ONE >> 1);

    logic [WEIGHT_W:0] w_inv;
    logic [PW-1:0]     m0_d;
    logic [PW-1:0]     m1_d;
    logic [PW-1:0]     m0_q;
    logic [PW-1:0]     m1_q;
    logic              va_q;
    logic [PW-1:0]     sum;

    // Weights sum to 2^T, so the rounded result never exceeds
    // the larger tap and cannot overflow DATA_WIDTH.
    always_comb begin
        w_inv = W_ONE - {1'b0, w};
        m0_d  = PW'(p0) * PW'(w_inv);
        m1_d  = PW'(p1) * PW'(w);
        sum   = m0_q + m1_q + RND;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            va_q      <= 1'b0;
            m0_q      <= '0;
            m1_q      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            va_q <= in_valid;
            if (in_valid) begin
                m0_q <= m0_d;
                m1_q <= m1_d;
            end
            out_valid <= va_q;
            if (va_q) begin
                out_data <= DATA_WIDTH'(sum >> WEIGHT_W);
            end
        end
    end

endmodule

// File: rtl/scaler_horizontal.sv
// scaler_horizontal: linear-interpolating horizontal downscaler, latency 3.
// Ports: clk, rst (sync, active-low), scale_step (4.12), di_i/de_i/hs_i/vs_i
//        in; do_o/de_o out, hs_o (=~hs_i delayed), vs_o (vs_i delayed).
module scaler_horizontal
    import scaler_pkg::*;
#(
    parameter int TABLE_INPUT_WIDTH = 10,
    parameter int PIXEL_STEP        = PIXEL_STEP_DEF,
    parameter int DATA_WIDTH        = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STEP_W-1:0]     scale_step,
    input  logic [DATA_WIDTH-1:0] di_i,
    input  logic                  de_i,
    input  logic                  hs_i,
    input  logic                  vs_i,
    output logic [DATA_WIDTH-1:0] do_o,
    output logic                  de_o,
    output logic                  hs_o,
    output logic                  vs_o
);

    localparam int F  = $clog2(PIXEL_STEP);
    localparam int T  = TABLE_INPUT_WIDTH;
    localparam int AW = INT_W + F;
    localparam logic [STEP_W-1:0] UNITY = STEP_W'(PIXEL_STEP);

    line_state_e state_q;
    line_state_e state_d;
    logic        line_clr;
    logic        accept;
    logic        emit;

    logic [AW-1:0]         pos_q;
    logic [INT_W-1:0]      n_q;
    logic [STEP_W-1:0]     step_q;
    logic [DATA_WIDTH-1:0] prev_q;
    logic [INT_W:0]        pos_idx;

    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_p0;
    logic [DATA_WIDTH-1:0] s1_p1;
    logic [T-1:0]          s1_w;

    logic [PIPE_LAT-1:0] hs_d;
    logic [PIPE_LAT-1:0] vs_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= LS_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Any blank cycle restarts the line; pixels are only taken
    // once a blank has been seen since reset.
    always_comb begin
        state_d  = state_q;
        line_clr = 1'b0;
        accept   = 1'b0;
        unique case (state_q)
            LS_WAIT: begin
                if (hs_i) begin
                    state_d  = LS_BLANK;
                    line_clr = 1'b1;
                end
            end
            LS_BLANK: begin
                if (hs_i) begin
                    line_clr = 1'b1;
                end else begin
                    state_d = LS_ACTIVE;
                    accept  = de_i;
                end
            end
            LS_ACTIVE: begin
                if (hs_i) begin
                    state_d  = LS_BLANK;
                    line_clr = 1'b1;
                end else begin
                    accept = de_i;
                end
            end
            default: begin
                state_d = LS_WAIT;
            end
        endcase
    end

    // Pixel n completes the pair (n-1, n); an output is due when
    // the integer source position lands on n-1.
    always_comb begin
        pos_idx = {1'b0, pos_q[AW-1:F]} + 1'b1;
        emit    = accept && (n_q != '0) && (pos_idx == {1'b0, n_q});
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pos_q    <= '0;
            n_q      <= '0;
            step_q   <= UNITY;
            prev_q   <= '0;
            s1_valid <= 1'b0;
            s1_p0    <= '0;
            s1_p1    <= '0;
            s1_w     <= '0;
        end else begin
            s1_valid <= emit;
            if (line_clr) begin
                pos_q  <= '0;
                n_q    <= '0;
                step_q <= clamp_step(scale_step, UNITY);
            end else if (accept) begin
                prev_q <= di_i;
                if (n_q != '1) begin
                    n_q <= n_q + 1'b1;
                end
                if (emit) begin
                    pos_q <= pos_q + AW'(step_q);
                    s1_p0 <= prev_q;
                    s1_p1 <= di_i;
                    s1_w  <= pos_q[F-1 -: T];
                end
            end
        end
    end

    scaler_h_interp #(
        .DATA_WIDTH (DATA_WIDTH),
        .WEIGHT_W   (T)
    ) u_interp (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid),
        .p0        (s1_p0),
        .p1        (s1_p1),
        .w         (s1_w),
        .out_valid (de_o),
        .out_data  (do_o)
    );

    // Sync delay matches the three data stages.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hs_d <= '0;
            vs_d <= '0;
        end else begin
            hs_d <= {hs_d[PIPE_LAT-2:0], ~hs_i};
            vs_d <= {vs_d[PIPE_LAT-2:0], vs_i};
        end
    end

    assign hs_o = hs_d[PIPE_LAT-1];
    assign vs_o = vs_d[PIPE_LAT-1];

endmodule

// File: tb/tb_scaler_horizontal.sv
// tb_scaler_horizontal: directed checks of the horizontal scaler.
// Ramp lines, hand-computed blend cases, gaps, step clamp, reset.
module tb_scaler_horizontal;

    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [15:0]   scale_step = 16'd4096;
    logic [DW-1:0] di = '0;
    logic          de = 1'b0;
    logic          hs = 1'b0;
    logic          vs = 1'b0;
    logic [DW-1:0] do_o;
    logic          de_o;
    logic          hs_o;
    logic          vs_o;

    scaler_horizontal #(
        .TABLE_INPUT_WIDTH (10),
        .PIXEL_STEP        (4096),
        .DATA_WIDTH        (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .scale_step (scale_step),
        .di_i       (di),
        .de_i       (de),
        .hs_i       (hs),
        .vs_i       (vs),
        .do_o       (do_o),
        .de_o       (de_o),
        .hs_o       (hs_o),
        .vs_o       (vs_o)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    int out_seen = 0;
    int eff_step = 4096;
    bit vs_sel = 1'b0;
    bit sync_chk = 1'b0;
    bit hold_chk = 1'b0;
    logic [DW-1:0] last_do = '0;

    int line_px[$];
    int line_exp[$];
    int exp_val[$];
    int exp_cyc[$];
    bit hs_hist[0:65535];
    bit vs_hist[0:65535];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        int ev;
        int ec;
        if (de_o === 1'b1) begin
            out_seen++;
            if (exp_val.size() == 0) begin
                chk("sb_empty", 32'(exp_val.size()), 1);
            end else begin
                ev = exp_val.pop_front();
                ec = exp_cyc.pop_front();
                chk("do_o", 32'(do_o), ev);
                chk("latency", cyc, ec);
            end
            last_do = do_o;
        end else if (hold_chk) begin
            chk("do_hold", 32'(do_o), 32'(last_do));
        end else begin
            last_do = do_o;
        end
        if (sync_chk) begin
            chk("hs_o", 32'(hs_o), 32'(!hs_hist[16'(cyc - 3)]));
            chk("vs_o", 32'(vs_o), 32'(vs_hist[16'(cyc - 3)]));
        end
    end

    task automatic step_cyc(input bit h, input bit d, input int px);
        @(posedge clk);
        #1;
        hs = h;
        vs = vs_sel;
        de = d;
        di = DW'(px);
        hs_hist[16'(cyc)] = h;
        vs_hist[16'(cyc)] = vs_sel;
    endtask

    task automatic blank(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            step_cyc(1'b1, i[0], 'h155 + i);
        end
    endtask

    task automatic set_ramp(input int w, input bit half);
        line_px.delete();
        line_exp.delete();
        for (int i = 0; i < w; i++) line_px.push_back(i);
        if (!half) begin
            for (int k = 0; k < w - 1; k++) line_exp.push_back(k);
        end else begin
            for (int k = 0; (3 * k) / 2 <= w - 2; k++) begin
                line_exp.push_back((k % 2 == 0) ? (3 * k) / 2
                                                : (3 * k + 1) / 2);
            end
        end
    endtask

    task automatic drive_line(input int gap, input int chg_at,
                              input logic [15:0] chg_val);
        int k;
        k = 0;
        for (int n = 0; n < line_px.size(); n++) begin
            if (n == chg_at) scale_step = chg_val;
            step_cyc(1'b0, 1'b1, line_px[n]);
            if (k < line_exp.size() && (k * eff_step) / 4096 + 1 == n) begin
                exp_val.push_back(line_exp[k]);
                exp_cyc.push_back(cyc + 3);
                k++;
            end
            for (int g = 0; g < gap; g++) step_cyc(1'b0, 1'b0, 'h2aa);
        end
    endtask

    task automatic run_line(input string tag, input int gap,
                            input int chg_at, input logic [15:0] chg_val);
        int seen0;
        blank(6);
        seen0 = out_seen;
        drive_line(gap, chg_at, chg_val);
        blank(5);
        chk(tag, out_seen - seen0, line_exp.size());
    endtask

    initial begin
        int seen0;

        repeat (3) step_cyc(1'b0, 1'b0, 0);
        chk("rst_de_o", 32'(de_o), 0);
        chk("rst_do_o", 32'(do_o), 0);
        chk("rst_hs_o", 32'(hs_o), 0);
        chk("rst_vs_o", 32'(vs_o), 0);
        rst = 1'b1;
        hold_chk = 1'b1;

        for (int i = 0; i < 20; i++) step_cyc(1'b0, 1'b1, i);
        repeat (4) step_cyc(1'b0, 1'b0, 0);
        chk("pre_hs_cnt", out_seen, 0);

        eff_step = 4096; scale_step = 16'd4096;
        set_ramp(600, 1'b0);
        run_line("cnt_1to1", 0, -1, 16'd0);

        eff_step = 6144; scale_step = 16'd6144;
        set_ramp(600, 1'b1);
        run_line("cnt_1p5", 0, -1, 16'd0);

        line_px = {50, 100, 200, 255, 255, 255, 255, 255};
        line_exp = {50, 150, 255, 255, 255};
        run_line("cnt_tbl_1p5", 0, -1, 16'd0);

        eff_step = 4096; scale_step = 16'd4096;
        line_exp = {50, 100, 200, 255, 255, 255, 255};
        run_line("cnt_tbl_1to1", 0, -1, 16'd0);

        eff_step = 5120; scale_step = 16'd5120;
        line_exp = {50, 125, 228, 255, 255, 255};
        run_line("cnt_tbl_1p25", 0, -1, 16'd0);

        eff_step = 4096; scale_step = 16'd2048;
        set_ramp(600, 1'b0);
        run_line("cnt_step2048", 0, -1, 16'd0);
        scale_step = 16'd0;
        run_line("cnt_step0", 0, -1, 16'd0);

        scale_step = 16'd4096;
        run_line("cnt_chg_mid", 0, 300, 16'd6144);
        eff_step = 6144;
        set_ramp(600, 1'b1);
        run_line("cnt_chg_next", 0, -1, 16'd0);

        sync_chk = 1'b1;
        for (int f = 0; f < 2; f++) begin
            vs_sel = 1'b1;
            blank(8);
            vs_sel = 1'b0;
            run_line("cnt_gap_a", 3, -1, 16'd0);
            run_line("cnt_gap_b", 3, -1, 16'd0);
        end
        sync_chk = 1'b0;

        eff_step = 4096; scale_step = 16'd4096;
        set_ramp(600, 1'b0);
        blank(6);
        seen0 = out_seen;
        hold_chk = 1'b0;
        for (int n = 0; n < 100; n++) begin
            step_cyc(1'b0, 1'b1, n);
            if (n >= 1 && n <= 97) begin
                exp_val.push_back(n - 1);
                exp_cyc.push_back(cyc + 3);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        di = DW'(100);
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk("mid_rst_de_o", 32'(de_o), 0);
        chk("mid_rst_do_o", 32'(do_o), 0);
        chk("mid_rst_hs_o", 32'(hs_o), 0);
        chk("mid_rst_vs_o", 32'(vs_o), 0);
        for (int n = 101; n < 150; n++) step_cyc(1'b0, 1'b1, n);
        repeat (4) step_cyc(1'b0, 1'b0, 0);
        chk("cnt_rst_line", out_seen - seen0, 97);
        hold_chk = 1'b1;
        run_line("cnt_after_rst", 0, -1, 16'd0);

        repeat (10) step_cyc(1'b1, 1'b0, 0);
        chk("sb_left", 32'(exp_val.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vec_cnt, err_cnt);
        $finish;
    end

endmodule
